// File: rtl/quantum_controller.sv
// -----------------------------------------------------------------------------
// quantum_controller
//
// Preemption timer and interrupt sequencer for the single-cycle processor.
// It counts retired user instructions against a programmable quantum. When the
// quantum runs out it raises intSig to the control decoder. intSig stays high
// until the decoder's interrupt path (stopQnt) retires. The block then idles
// until the OS reloads a quantum with writei (WriteI).
//
// Ports:
//   clk            in   system clock; all state updates on the rising edge
//   reset          in   synchronous, active-high reset
//   instr_valid    in   an instruction retires this cycle
//   Halt           in   processor stalled; retirement frozen
//   WriteI         in   writei retiring; load a new quantum
//   stopQnt        in   interrupt path retiring this cycle
//   qnt_value      in   new quantum (register operand of writei)
//   pc_in          in   PC of the instruction retiring this cycle
//   intSig         out  registered interrupt request to the control decoder
//   saved_pc       out  PC captured when the interrupt retired
//   qnt_remaining  out  current down-counter value
//   timer_active   out  high while in COUNT
//   irq_count      out  number of interrupts taken (wraps)
// -----------------------------------------------------------------------------
module quantum_controller #(
  parameter int QNT_WIDTH       = 16,
  parameter int DEFAULT_QUANTUM = 100,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic                 Halt,
  input  logic                 WriteI,
  input  logic                 stopQnt,
  input  logic [QNT_WIDTH-1:0] qnt_value,
  input  logic [31:0]          pc_in,
  output logic                 intSig,
  output logic [31:0]          saved_pc,
  output logic [QNT_WIDTH-1:0] qnt_remaining,
  output logic                 timer_active,
  output logic [CNT_WIDTH-1:0] irq_count
);

  // IDLE : OS running, timer off
  // ARM  : one-instruction grace for the OS jump into user code
  // COUNT: user code running, counting retires
  // FIRE : interrupt requested, waiting for the interrupt path to retire
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_FIRE  = 2'd3;

  logic [1:0]           state;
  logic [QNT_WIDTH-1:0] quantum_reg;
  logic                 retire;

  // Saturating decrement: the counter never wraps below zero.
  function automatic logic [QNT_WIDTH-1:0] dec_sat(input logic [QNT_WIDTH-1:0] v);
    if (v == '0)
      return '0;
    else
      return v - QNT_WIDTH'(1);
  endfunction

  // Modulo increment of the statistics counter.
  function automatic logic [CNT_WIDTH-1:0] inc_wrap(input logic [CNT_WIDTH-1:0] v);
    return v + CNT_WIDTH'(1);
  endfunction

  // A retire is the only event that advances anything besides reset.
  assign retire       = instr_valid && !Halt;
  assign timer_active = (state == S_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      intSig        <= 1'b0;
      saved_pc      <= '0;
      qnt_remaining <= '0;
      irq_count     <= '0;
      quantum_reg   <= QNT_WIDTH'(DEFAULT_QUANTUM);
    end else if (retire) begin
      case (state)
        S_IDLE: begin
          if (WriteI) begin
            quantum_reg <= qnt_value;
            // qnt_remaining is already 0 in IDLE, so loading a zero quantum
            // leaves it unchanged and the timer stays disabled.
            qnt_remaining <= qnt_value;
            if (qnt_value != '0)
              state <= S_ARM;
          end
        end

        S_ARM: begin
          if (WriteI) begin
            quantum_reg   <= qnt_value;
            qnt_remaining <= qnt_value;
            state         <= (qnt_value != '0) ? S_ARM : S_IDLE;
          end else begin
            // The grace retire is not counted.
            state <= S_COUNT;
          end
        end

        S_COUNT: begin
          // A reload wins over both the decrement and the expiry.
          if (WriteI) begin
            quantum_reg   <= qnt_value;
            qnt_remaining <= qnt_value;
            state         <= (qnt_value != '0) ? S_ARM : S_IDLE;
          end else if (qnt_remaining == QNT_WIDTH'(1)) begin
            qnt_remaining <= '0;
            intSig        <= 1'b1;
            state         <= S_FIRE;
          end else begin
            qnt_remaining <= dec_sat(qnt_remaining);
          end
        end

        S_FIRE: begin
          // WriteI is ignored here; only the interrupt path leaves FIRE.
          if (stopQnt) begin
            saved_pc  <= pc_in;
            irq_count <= inc_wrap(irq_count);
            intSig    <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state  <= S_IDLE;
          intSig <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/quantum_controller.md
Name: quantum_controller

Overview:
Preemption timer and interrupt sequencer for the single-cycle processor. It counts retired user instructions against a programmable quantum and raises intSig to the control decoder when the quantum expires. It holds intSig until the decoder's interrupt path (stopQnt) retires, then idles until the OS reloads a quantum through the writei instruction (WriteI). It sits between the control decoder, the PC update logic and the register-file read port that supplies the quantum value.

Parameters:
QNT_WIDTH, 16, width of quantum register and down-counter
DEFAULT_QUANTUM, 100, quantum_reg value after reset
CNT_WIDTH, 8, width of the interrupt statistics counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  an instruction retires this cycle (PC advances)
Halt  input  1  from control decoder; processor stalled (halt or in), retirement frozen
WriteI  input  1  from control decoder; writei retiring, load quantum
stopQnt  input  1  from control decoder; interrupt path retiring this cycle
qnt_value  input  QNT_WIDTH  new quantum (register operand of writei)
pc_in  input  32  PC of the instruction retiring this cycle
intSig  output  1  interrupt request to control decoder, registered
saved_pc  output  32  PC captured when interrupt retired
qnt_remaining  output  QNT_WIDTH  current down-counter value
timer_active  output  1  high in COUNT state
irq_count  output  CNT_WIDTH  number of interrupts taken, wraps

Behaviour:
- Retire event R = instr_valid && !Halt. No state change other than reset happens without R.
- Reset (synchronous, priority over everything): state=IDLE, intSig=0, saved_pc=0, qnt_remaining=0, timer_active=0, irq_count=0, quantum_reg=DEFAULT_QUANTUM. Reset mid-COUNT or mid-FIRE discards the pending interrupt.
- States: IDLE (OS running, timer off), ARM (one-instruction grace), COUNT (user running), FIRE (intSig asserted).
- IDLE: on R && WriteI: quantum_reg<=qnt_value. If qnt_value==0, stay IDLE (timer disabled). Else qnt_remaining<=qnt_value and go to ARM.
- ARM: the next R (the OS jump into user code) is not counted; go to COUNT. R && WriteI in ARM reloads, with the same zero rule.
- COUNT: on each R, qnt_remaining decrements by 1. When R occurs with qnt_remaining==1: qnt_remaining<=0, go to FIRE, intSig=1 from the next cycle. R && WriteI in COUNT reloads the counter and returns to ARM, taking priority over decrement and expiry.
- FIRE: intSig held at 1 through any Halt stall. On R && stopQnt: saved_pc<=pc_in, irq_count<=irq_count+1 (modulo 2^CNT_WIDTH, 255->0 at default), intSig<=0, go to IDLE. WriteI in FIRE is ignored.
- Latency: expiry retire at cycle N gives intSig=1 at N+1. Interrupt retire at M gives intSig=0 at M+1.
- timer_active is 1 only in COUNT. qnt_remaining never wraps below 0.

Test Plan:
- Reset, then WriteI with qnt_value=3 and 5 consecutive retires -> grace retire not counted; qnt_remaining 3,2,1,0; intSig=1 in the cycle after the 4th post-load retire.
- FIRE with Halt=1 for 10 cycles, then stopQnt retire with pc_in=0x40 -> intSig stays 1 throughout; then saved_pc=0x40, irq_count=1, intSig=0, state IDLE.
- WriteI with qnt_value=0 -> timer_active stays 0, intSig never asserts over 1000 retires, quantum_reg=0.
- In COUNT with qnt_remaining=1, retire carrying WriteI and qnt_value=7 -> no interrupt; qnt_remaining=7, state ARM.
- Assert reset in FIRE -> next cycle intSig=0, irq_count=0, quantum_reg=100, state IDLE.
- 256 complete interrupt cycles with quantum 1 -> irq_count wraps to 0; saved_pc tracks the last pc_in.
